debug_pattern_generator: RTL and testbench
==========================================

# debug_pattern_generator

Free-running colour-bar test-pattern source for the LCD path. It writes a framed stream of 17-bit words (commands plus RGB565 pixels) into the LCD queue FIFO, standing in for the camera/framebuffer so the display pipeline can be brought up and checked in isolation. Each frame consists of vertical colour bars, identical on every row, and frames repeat back-to-back indefinitely.

## Interface
- `FRAME_WIDTH`, default 480: pixels per row.
- `FRAME_HEIGHT`, default 272: rows per frame.
- `NUM_COLOR_BARS`, default 10: number of vertical bars; range 1..10.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `queue_full` input, 1 bit: the downstream FIFO is full; no write is allowed while it is high.
- `queue_data` output, 17 bits: word to the FIFO.
  - Bit 16 = 1 marks a command word.
  - Bit 16 = 0 marks a pixel, with RGB565 in bits [15:0].
- `queue_wr_en` output, 1 bit: write strobe; `queue_data` is accepted on any cycle where it is high.

## Operation
- Command words:
  - Frame start: 0x10000.
  - Row start: 0x10001.
  - Frame end: 0x1FFFF.
- Per-frame word order:
  - Frame start.
  - Then FRAME_HEIGHT repetitions of: row start followed by FRAME_WIDTH pixel words.
  - Then frame end.
  - The next frame start follows immediately, with no gap.
- State machine:
  - FRAME_START → ROW_START → PIXELS.
  - PIXELS → ROW_START after the last pixel of a row, unless it was the last row.
  - PIXELS → FRAME_END after the last pixel of the last row.
  - FRAME_END → FRAME_START.
  - Each state emits its word, then advances only on an accepted write.
- Bar geometry:
  - BAR_WIDTH = FRAME_WIDTH / NUM_COLOR_BARS, using integer division (48 at the defaults).
  - Column c (0-based) belongs to bar b = floor(c / BAR_WIDTH).
  - Columns with c ≥ NUM_COLOR_BARS·BAR_WIDTH (the division remainder) output 0x0000.
  - Implement with a bar index plus an in-bar counter; do not use a divider.
- Palette, matching `ColorUtilities::get_rgb_color(i)` in RGB565:
  - 0: white 0xFFFF
  - 1: yellow 0xFFE0
  - 2: cyan 0x07FF
  - 3: green 0x07E0
  - 4: magenta 0xF81F
  - 5: red 0xF800
  - 6: blue 0x001F
  - 7: black 0x0000
  - 8: gray 0x8410
  - 9: orange 0xFD20
- Counter widths:
  - Column counter: $clog2(FRAME_WIDTH+1) bits.
  - Row counter: $clog2(FRAME_HEIGHT+1) bits.
  - No counter wraps mid-frame.
  - Column and bar counters clear on every row start.
  - The row counter clears on every frame start.

## Timing
- Handshake:
  - `queue_wr_en = valid & ~queue_full`, combinational on `queue_full`.
  - `valid` is high in every non-reset state.
  - `queue_data` is driven from registered state and is stable whenever `queue_wr_en` is high.
- Throughput: one word per clock while `queue_full` is low.
- Backpressure:
  - While `queue_full` is high, hold the state, counters and `queue_data`.
  - No word is dropped or duplicated across full periods of any length.
- Reset:
  - While `reset` is high: `queue_wr_en` = 0, `queue_data` = 0x10000, state = FRAME_START, all counters = 0.
  - On the first clock edge after `reset` falls, `queue_wr_en` rises with 0x10000, provided `queue_full` is low.
- Reset mid-frame abandons the current frame immediately. The next output is a fresh frame start, with no frame end emitted.
- Frame length at the defaults: 1 + 272·(1+480) + 1 = 130,834 words.

## Test plan
- Reset release with `queue_full` held low:
  - 1st word is 0x10000, 2nd is 0x10001.
  - Pixels 0–47 are 0xFFFF, 48–95 are 0xFFE0, …, 432–479 are 0xFD20.
  - Then 0x10001 follows.
- Full frame through the 17-bit FIFO, read at a slower unrelated clock:
  - 272 rows each match the bar pattern.
  - 0x1FFFF is the 130,834th word, followed by 0x10000.
- Random `queue_full` toggling (≈50% duty) for one frame → the received sequence is identical to the no-backpressure run, and `queue_wr_en` is never high while `queue_full` is high.
- FRAME_WIDTH=485, NUM_COLOR_BARS=10:
  - BAR_WIDTH is 48.
  - Columns 480–484 are 0x0000.
  - Every row has 485 pixels.
- Assert `reset` during row 100, column 200, for 1 cycle → the next written word is 0x10000, and no 0x1FFFF precedes it.
- FRAME_HEIGHT=2, FRAME_WIDTH=10, NUM_COLOR_BARS=5 → words: 0x10000, 0x10001, FFFF FFFF FFE0 FFE0 07FF 07FF 07E0 07E0 F81F F81F, 0x10001, the same 10 pixels, 0x1FFFF, 0x10000.

Source files
------------

// File: rtl/debug_pattern_generator.sv
// Free-running vertical colour-bar source for the LCD queue FIFO.
// It emits framed 17-bit words: commands with bit 16 set, and RGB565 pixels with bit 16 clear.
module debug_pattern_generator #(
   parameter int FRAME_WIDTH    = 480,
   parameter int FRAME_HEIGHT   = 272,
   parameter int NUM_COLOR_BARS = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        queue_full,
   output logic [16:0] queue_data,
   output logic        queue_wr_en
);

   localparam int BAR_W = FRAME_WIDTH / NUM_COLOR_BARS;
   localparam int COL_W = $clog2(FRAME_WIDTH + 1);
   localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);
   localparam int IN_W  = $clog2(BAR_W + 1);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);
   localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(BAR_W - 1);
   localparam logic [3:0]       BAR_END  = 4'(NUM_COLOR_BARS);

   typedef enum logic [1:0] {
      FRAME_START,
      ROW_START,
      PIXELS,
      FRAME_END
   } state_t;

   state_t           state, state_next;
   logic             active;
   logic             accept;
   logic             last_col, last_row;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [3:0]       bar;
   logic [IN_W-1:0]  in_bar;
   logic [15:0]      pixel;

   function automatic logic [15:0] bar_color(input logic [3:0] idx);
      case (idx)
         4'd0:    bar_color = 16'hFFFF;
         4'd1:    bar_color = 16'hFFE0;
         4'd2:    bar_color = 16'h07FF;
         4'd3:    bar_color = 16'h07E0;
         4'd4:    bar_color = 16'hF81F;
         4'd5:    bar_color = 16'hF800;
         4'd6:    bar_color = 16'h001F;
         4'd7:    bar_color = 16'h0000;
         4'd8:    bar_color = 16'h8410;
         4'd9:    bar_color = 16'hFD20;
         default: bar_color = 16'h0000;
      endcase
   endfunction

   // active is set one edge after reset falls, so the first write follows that edge.
   assign queue_wr_en = active & ~reset & ~queue_full;
   assign accept      = queue_wr_en;
   assign last_col    = (col == COL_LAST);
   assign last_row    = (row == ROW_LAST);
   // The remainder columns past the last whole bar are black.
   assign pixel       = (bar < BAR_END) ? bar_color(bar) : 16'h0000;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= FRAME_START;
         active <= 1'b0;
      end else begin
         state  <= state_next;
         active <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      queue_data = 17'h10000;
      case (state)
         FRAME_START: begin
            queue_data = 17'h10000;
            if (accept) state_next = ROW_START;
         end
         ROW_START: begin
            queue_data = 17'h10001;
            if (accept) state_next = PIXELS;
         end
         PIXELS: begin
            queue_data = {1'b0, pixel};
            if (accept && last_col) state_next = last_row ? FRAME_END : ROW_START;
         end
         FRAME_END: begin
            queue_data = 17'h1FFFF;
            if (accept) state_next = FRAME_START;
         end
         default: state_next = FRAME_START;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col    <= '0;
         row    <= '0;
         bar    <= '0;
         in_bar <= '0;
      end else if (accept) begin
         case (state)
            FRAME_START: row <= '0;
            ROW_START: begin
               col    <= '0;
               bar    <= '0;
               in_bar <= '0;
            end
            PIXELS: begin
               if (last_col) begin
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
                  if (bar < BAR_END) begin
                     if (in_bar == IN_LAST) begin
                        in_bar <= '0;
                        bar    <= bar + 1'b1;
                     end else begin
                        in_bar <= in_bar + 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_pattern_generator.sv
// Directed bench for debug_pattern_generator: default geometry, a remainder-column geometry,
// and a tiny frame with and without random backpressure.
module tb_debug_pattern_generator;

   logic        clk = 1'b0;
   logic        rst_a, reset;
   logic        full_a, full_b, full_c, full_d;
   logic [16:0] data_a, data_b, data_c, data_d;
   logic        wr_en_a, wr_en_b, wr_en_c, wr_en_d;

   logic [16:0] qa[$], qb[$], qc[$], qd[$];
   logic [16:0] exp_small[$];
   int          n_checks = 0;
   int          n_errors = 0;

   logic [15:0] pal [10] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F,
                             16'hF800, 16'h001F, 16'h0000, 16'h8410, 16'hFD20};
   logic [15:0] pix10 [10] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF,
                               16'h07FF, 16'h07E0, 16'h07E0, 16'hF81F, 16'hF81F};

   always #5 clk = ~clk;

   debug_pattern_generator dut_a (
      .clk(clk), .reset(rst_a), .queue_full(full_a), .queue_data(data_a), .queue_wr_en(wr_en_a));

   debug_pattern_generator #(.FRAME_WIDTH(485), .FRAME_HEIGHT(3), .NUM_COLOR_BARS(10)) dut_b (
      .clk(clk), .reset(reset), .queue_full(full_b), .queue_data(data_b), .queue_wr_en(wr_en_b));

   debug_pattern_generator #(.FRAME_WIDTH(10), .FRAME_HEIGHT(2), .NUM_COLOR_BARS(5)) dut_c (
      .clk(clk), .reset(reset), .queue_full(full_c), .queue_data(data_c), .queue_wr_en(wr_en_c));

   debug_pattern_generator #(.FRAME_WIDTH(10), .FRAME_HEIGHT(2), .NUM_COLOR_BARS(5)) dut_d (
      .clk(clk), .reset(reset), .queue_full(full_d), .queue_data(data_d), .queue_wr_en(wr_en_d));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Capture every accepted word; the FIFO takes it on the following rising edge.
   always @(negedge clk) begin
      if (wr_en_a) qa.push_back(data_a);
      if (wr_en_b) qb.push_back(data_b);
      if (wr_en_c) qc.push_back(data_c);
      if (wr_en_d) qd.push_back(data_d);
      if (full_c) check("c_wr_en_while_full", {31'd0, wr_en_c}, 32'd0);
   end

   initial begin
      full_c = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         full_c = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int s0, mark, n_end;
      bit ok;

      for (int f = 0; f < 2; f++) begin
         exp_small.push_back(17'h10000);
         for (int r = 0; r < 2; r++) begin
            exp_small.push_back(17'h10001);
            for (int p = 0; p < 10; p++) exp_small.push_back({1'b0, pix10[p]});
         end
         exp_small.push_back(17'h1FFFF);
      end
      exp_small.push_back(17'h10000);

      rst_a = 1'b1; reset = 1'b1;
      full_a = 1'b0; full_b = 1'b0; full_d = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("a_reset_wr_en", {31'd0, wr_en_a}, 32'd0);
      check("a_reset_data", {15'd0, data_a}, 32'h10000);
      check("d_reset_wr_en", {31'd0, wr_en_d}, 32'd0);

      @(posedge clk); #1;
      rst_a = 1'b0; reset = 1'b0;
      @(negedge clk);
      check("a_wr_en_before_edge", {31'd0, wr_en_a}, 32'd0);
      @(negedge clk);
      check("a_first_wr_en", {31'd0, wr_en_a}, 32'd1);
      check("a_first_word", {15'd0, data_a}, 32'h10000);

      #1;
      s0 = qd.size();
      repeat (20) @(negedge clk);
      #1;
      check("d_throughput", qd.size() - s0, 32'd20);

      for (int i = 0; i < 2000 && (qc.size() < 49 || qd.size() < 49); i++) begin
         @(negedge clk); #1;
      end
      ok = (qc.size() >= 49) && (qd.size() >= 49);
      check("cd_timeout", {31'd0, ok}, 32'd1);
      if (ok) begin
         for (int k = 0; k < 49; k++) begin
            check($sformatf("d_word%0d", k), {15'd0, qd[k]}, {15'd0, exp_small[k]});
            check($sformatf("c_bp_word%0d", k), {15'd0, qc[k]}, {15'd0, exp_small[k]});
         end
      end

      for (int i = 0; i < 5000 && qb.size() < 1461; i++) begin
         @(negedge clk); #1;
      end
      ok = (qb.size() >= 1461);
      check("b_timeout", {31'd0, ok}, 32'd1);
      if (ok) begin
         check("b_frame_start", {15'd0, qb[0]}, 32'h10000);
         for (int r = 0; r < 3; r++) begin
            check($sformatf("b_row%0d_start", r), {15'd0, qb[1 + r*486]}, 32'h10001);
            for (int c = 0; c < 485; c++)
               check($sformatf("b_r%0d_c%0d", r, c), {15'd0, qb[2 + r*486 + c]},
                     (c < 480) ? {16'd0, pal[c/48]} : 32'd0);
         end
         check("b_frame_end", {15'd0, qb[1459]}, 32'h1FFFF);
         check("b_next_frame", {15'd0, qb[1460]}, 32'h10000);
      end

      ok = (qa.size() >= 483);
      check("a_row0_len", {31'd0, ok}, 32'd1);
      if (ok) begin
         check("a_word0", {15'd0, qa[0]}, 32'h10000);
         check("a_word1", {15'd0, qa[1]}, 32'h10001);
         for (int c = 0; c < 480; c++)
            check($sformatf("a_r0_c%0d", c), {15'd0, qa[2 + c]}, {16'd0, pal[c/48]});
         check("a_row1_start", {15'd0, qa[482]}, 32'h10001);
      end

      // Word index 48302 is row 100, column 200.
      for (int i = 0; i < 60000 && qa.size() < 48302; i++) begin
         @(negedge clk); #1;
      end
      ok = (qa.size() == 48302);
      check("a_reach_row100", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      check("a_r100_c200_live", {15'd0, data_a}, 32'h0F81F);
      rst_a = 1'b1;
      @(posedge clk); #1;
      rst_a = 1'b0;
      mark = 48302;
      check("a_no_write_in_reset", qa.size(), mark);
      for (int i = 0; i < 100 && qa.size() < mark + 2; i++) begin
         @(negedge clk); #1;
      end
      ok = (qa.size() >= mark + 2);
      check("a_after_reset_timeout", {31'd0, ok}, 32'd1);
      if (ok) begin
         check("a_r100_c199", {15'd0, qa[mark-1]}, 32'h0F81F);
         check("a_restart_frame", {15'd0, qa[mark]}, 32'h10000);
         check("a_restart_row", {15'd0, qa[mark+1]}, 32'h10001);
         n_end = 0;
         for (int k = 0; k < mark + 1; k++) if (qa[k] == 17'h1FFFF) n_end++;
         check("a_no_frame_end", n_end, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
